capi_fpga_reset_seq: RTL
========================

CAPI_FPGA_RESET_SEQ -- requirements
Module: capi_fpga_reset_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of staged reset channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 10: width of the main and gap counters.
REQ-003 SHALL have parameter COUNT_TO, default 1000: number of cycles from entry into COUNT to release of channel 0.
REQ-004 SHALL have parameter STAGE_GAP, default 16: number of cycles between releases of consecutive channels.
REQ-005 SHALL have parameter LOCK_FILT, default 8: number of consecutive synchronised-high lock cycles required to declare lock.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port PLL_LOCKED, input, 1 bit: asynchronous PLL lock indication.
REQ-009 SHALL have port SW_RST_REQ, input, 1 bit: single-cycle software reset-restart request.
REQ-010 SHALL have port LOCK_LOST_CLR, input, 1 bit: clears the sticky LOCK_LOST flag.
REQ-011 SHALL have port RST_OUT, output, NUM_CH bits: active-high reset per channel.
REQ-012 SHALL have port ALL_DONE, output, 1 bit: high when all channels are released.
REQ-013 SHALL have port SW_RST_ACK, output, 1 bit: one-cycle acknowledge of an accepted SW_RST_REQ.
REQ-014 SHALL have port LOCK_LOST, output, 1 bit: sticky flag, set when lock drops while in STAGE or RUN.

Function
REQ-015 SHALL synchronise PLL_LOCKED through 2 flops; lock_ok SHALL rise after LOCK_FILT consecutive synchronised-high cycles and fall on the first synchronised-low cycle.
REQ-016 SHALL implement states WAIT_LOCK, COUNT, STAGE and RUN.
REQ-017 WAIT_LOCK: all RST_OUT=1; on lock_ok=1 go to COUNT and clear the main counter.
REQ-018 COUNT: main counter increments each cycle; on the COUNT_TO-th edge after entry, go to STAGE with RST_OUT[0]=0 and the channel index set to 1.
REQ-019 STAGE: gap counter runs; every STAGE_GAP cycles deassert RST_OUT[index] and increment index; when RST_OUT[NUM_CH-1] deasserts, enter RUN in the same edge.
REQ-020 SHALL release channels in ascending order only; a released channel SHALL stay low until a restart.
REQ-021 With NUM_CH=1, COUNT SHALL go directly to RUN.
REQ-022 RUN: ALL_DONE=1 and RST_OUT=0; ALL_DONE SHALL be 0 in every other state.
REQ-023 On lock_ok=0 in any state other than WAIT_LOCK: next edge enters WAIT_LOCK, all RST_OUT=1, ALL_DONE=0, counters cleared.
REQ-024 LOCK_LOST SHALL be set when lock drops in STAGE or RUN, but not when it drops in COUNT.
REQ-025 SW_RST_REQ=1 in COUNT, STAGE or RUN SHALL restart COUNT with all RST_OUT=1 and the counter cleared, with SW_RST_ACK=1 for exactly the next cycle.
REQ-026 SW_RST_REQ in WAIT_LOCK SHALL be ignored, with no ack.
REQ-027 When lock loss and SW_RST_REQ occur in the same cycle, lock loss wins: state goes to WAIT_LOCK and no ack is given.
REQ-028 When LOCK_LOST_CLR and a set event occur in the same cycle, set wins.
REQ-029 Counters SHALL be CNT_W bits wide and never wrap; compares SHALL be exact equality.
REQ-030 Elaboration SHALL fail unless 1<=COUNT_TO<2**CNT_W, 1<=STAGE_GAP<2**CNT_W, LOCK_FILT>=1 and 1<=NUM_CH<=8.
REQ-031 All RST_OUT and ALL_DONE SHALL be driven directly from flops, with no combinational glitch path.

Reset
REQ-032 RESET=1 SHALL, at the next edge, give state WAIT_LOCK, RST_OUT all 1, ALL_DONE=0, SW_RST_ACK=0, LOCK_LOST=0, counters 0, filter 0 and synchroniser flops 0.
REQ-033 RESET asserted mid-sequence SHALL override all other events; after release, lock SHALL be re-qualified from zero.

Structure
REQ-034 State encoding localparams and the parameter-legality check SHALL live in shared package capi_reset_pkg, reused by future reset blocks.
REQ-035 The synchroniser plus lock filter SHALL be sub-module capi_lock_filter, with ports CLK, RESET, PLL_LOCKED, LOCK_FILT parameter and output lock_ok.
REQ-036 The remaining FSM and counters SHALL be flat in capi_fpga_reset_seq.

Verification (NUM_CH=3, COUNT_TO=20, STAGE_GAP=4, LOCK_FILT=8)
REQ-037 Bench SHALL check: RESET for 5 cycles, then PLL_LOCKED=1 -> lock_ok 10 cycles later; RST_OUT[0] low 20 cycles after COUNT entry, [1] at +4, [2] at +8; ALL_DONE rises with [2].
REQ-038 Bench SHALL check: PLL_LOCKED glitching low 1 cycle every 5 cycles -> lock_ok never asserts and RST_OUT stays 3'b111.
REQ-039 Bench SHALL check: in RUN, PLL_LOCKED=0 -> 3 edges later RST_OUT=3'b111 and LOCK_LOST=1; it holds until a LOCK_LOST_CLR pulse.
REQ-040 Bench SHALL check: SW_RST_REQ in STAGE after channel 0 released -> RST_OUT=3'b111 next edge, SW_RST_ACK a 1-cycle pulse, full 20+4+4 sequence replays.
REQ-041 Bench SHALL check: SW_RST_REQ in the same cycle lock_ok falls -> WAIT_LOCK, SW_RST_ACK stays 0.
REQ-042 Bench SHALL check: RESET asserted in COUNT at counter=15 -> all outputs at reset values next edge; after release, the sequence restarts from lock qualification.

Source files
------------

// File: rtl/capi_reset_pkg.sv
// Shared definitions for staged reset sequencers: state encoding and the
// parameter legality check used at elaboration.
package capi_reset_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT_LOCK = 2'd0;
  localparam state_t ST_COUNT     = 2'd1;
  localparam state_t ST_STAGE     = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  localparam int MAX_CH = 8;

  function automatic bit params_legal(input int num_ch, input int cnt_w,
                                      input int count_to, input int stage_gap,
                                      input int lock_filt);
    longint lim;
    if (cnt_w < 1 || cnt_w > 32) return 1'b0;
    lim = longint'(1) << cnt_w;
    return (num_ch >= 1) && (num_ch <= MAX_CH) &&
           (count_to >= 1) && (longint'(count_to) < lim) &&
           (stage_gap >= 1) && (longint'(stage_gap) < lim) &&
           (lock_filt >= 1);
  endfunction

endpackage

// File: rtl/capi_lock_filter.sv
// Two-flop synchroniser for the PLL lock input followed by a consecutive-high
// filter; lock_ok drops on the first synchronised-low cycle.
module capi_lock_filter #(
  parameter int LOCK_FILT = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PLL_LOCKED,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);

  logic          sync1_q, sync2_q;
  logic [FW-1:0] filt_q, filt_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= '0;
    end else begin
      sync1_q <= PLL_LOCKED;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
    end
  end

  // Saturating run-length of synchronised-high cycles.
  always_comb begin
    filt_d = '0;
    if (sync2_q) filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + 1'b1;
  end

  assign lock_ok = sync2_q && (filt_q == FILT_MAX);

endmodule

// File: rtl/capi_fpga_reset_seq.sv
// Staged reset sequencer: waits for filtered PLL lock, counts a settle time,
// then releases NUM_CH resets in ascending order, one every STAGE_GAP cycles.
module capi_fpga_reset_seq
  import capi_reset_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 10,
  parameter int COUNT_TO  = 1000,
  parameter int STAGE_GAP = 16,
  parameter int LOCK_FILT = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PLL_LOCKED,
  input  logic              SW_RST_REQ,
  input  logic              LOCK_LOST_CLR,
  output logic [NUM_CH-1:0] RST_OUT,
  output logic              ALL_DONE,
  output logic              SW_RST_ACK,
  output logic              LOCK_LOST
);

  if (!params_legal(NUM_CH, CNT_W, COUNT_TO, STAGE_GAP, LOCK_FILT)) begin : g_param_check
    $error("capi_fpga_reset_seq: illegal parameter combination");
  end

  localparam int IDX_W = 3;
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);

  logic lock_ok;

  capi_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
    .CLK        (CLK),
    .RESET      (RESET),
    .PLL_LOCKED (PLL_LOCKED),
    .lock_ok    (lock_ok)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;
  logic               lost_q, lost_d;

  logic lock_drop, sw_restart, cnt_done, gap_done, last_ch;

  // Lock loss outranks a software restart in the same cycle.
  assign lock_drop  = (state_q != ST_WAIT_LOCK) && !lock_ok;
  assign sw_restart = (state_q != ST_WAIT_LOCK) && lock_ok && SW_RST_REQ;
  assign cnt_done   = (state_q == ST_COUNT) && (cnt_q == COUNT_LAST);
  assign gap_done   = (state_q == ST_STAGE) && (gap_q == GAP_LAST);
  assign last_ch    = (idx_q == IDX_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (cnt_done) begin
          state_d = (NUM_CH == 1) ? ST_RUN : ST_STAGE;
          cnt_d   = '0;
          gap_d   = '0;
          idx_d   = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STAGE: begin
        if (gap_done) begin
          gap_d = '0;
          if (last_ch) state_d = ST_RUN;
          else         idx_d   = idx_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (sw_restart) begin
      state_d = ST_COUNT;
      cnt_d   = '0;
      gap_d   = '0;
      idx_d   = '0;
    end
    if (lock_drop) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      gap_d   = '0;
      idx_d   = '0;
    end
  end

  // Next values for the registered outputs, so no output sees a comb path.
  always_comb begin
    rst_d  = rst_q;
    done_d = done_q;
    ack_d  = 1'b0;
    lost_d = LOCK_LOST_CLR ? 1'b0 : lost_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        rst_d  = '1;
        done_d = 1'b0;
      end
      ST_COUNT: begin
        if (cnt_done) begin
          rst_d[0] = 1'b0;
          if (NUM_CH == 1) done_d = 1'b1;
        end
      end
      ST_STAGE: begin
        if (gap_done) begin
          for (int i = 1; i < NUM_CH; i++) begin
            if (IDX_W'(i) == idx_q) rst_d[i] = 1'b0;
          end
          if (last_ch) done_d = 1'b1;
        end
      end
      ST_RUN: begin
        rst_d  = '0;
        done_d = 1'b1;
      end
      default: ;
    endcase
    if (sw_restart) begin
      rst_d  = '1;
      done_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (lock_drop) begin
      rst_d  = '1;
      done_d = 1'b0;
      ack_d  = 1'b0;
      if (state_q == ST_STAGE || state_q == ST_RUN) lost_d = 1'b1;
    end
  end

  assign RST_OUT    = rst_q;
  assign ALL_DONE   = done_q;
  assign SW_RST_ACK = ack_q;
  assign LOCK_LOST  = lost_q;

endmodule
